// File: rtl/glyph_serializer.sv
// Streams one 5x5 operator glyph as a scaled valid/ready pixel raster with a done pulse.
// Optional build macro GLYPH_INVERT_EN adds an "invert" input for reverse-video rendering.
module glyph_serializer #(
  parameter int SCALE_X = 1,
  parameter int SCALE_Y = 1,
  localparam int GW = 5 * SCALE_X,
  localparam int GH = 5 * SCALE_Y,
  localparam int XW = $clog2(GW),
  localparam int YW = $clog2(GH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    code,
`ifdef GLYPH_INVERT_EN
  input  logic          invert,
`endif
  output logic          busy,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_on,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  localparam logic [XW-1:0] X_LAST  = XW'(GW - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(GH - 1);
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  localparam logic [2:0]    SX_LAST = 3'(SCALE_X - 1);
  localparam logic [2:0]    SY_LAST = 3'(SCALE_Y - 1);

  // Row bitmap of a glyph, MSB is the leftmost column.
  function automatic logic [4:0] rom_row(input logic [2:0] c, input logic [2:0] r);
    logic [24:0] g;
    case (c)
      3'd1:    g = 25'b00100_00100_11111_00100_00100;
      3'd2:    g = 25'b00000_00000_11111_00000_00000;
      3'd3:    g = 25'b10001_01010_00100_01010_10001;
      3'd4:    g = 25'b00100_00000_11111_00000_00100;
      3'd5:    g = 25'b00000_11111_00000_11111_00000;
      3'd6:    g = 25'b11111_11111_11111_11111_11111;
      default: g = 25'd0;
    endcase
    case (r)
      3'd0:    rom_row = g[24:20];
      3'd1:    rom_row = g[19:15];
      3'd2:    rom_row = g[14:10];
      3'd3:    rom_row = g[9:5];
      3'd4:    rom_row = g[4:0];
      default: rom_row = 5'd0;
    endcase
  endfunction

  state_t        state_r, state_n;
  logic [2:0]    code_r, code_n;
  logic          inv_r, inv_n, inv_in_s;
  logic [XW-1:0] x_r, x_n;
  logic [YW-1:0] y_r, y_n;
  logic [2:0]    sx_r, sx_n, sy_r, sy_n;
  logic [2:0]    col_r, col_n, row_r, row_n;
  logic [4:0]    row_bits_s;
  logic          on_n;

`ifdef GLYPH_INVERT_EN
  assign inv_in_s = invert;
`else
  assign inv_in_s = 1'b0;
`endif

  assign pix_x = x_r;
  assign pix_y = y_r;

  // Next-state, raster counters and the registered-output precompute.
  always_comb begin
    state_n = state_r;
    code_n  = code_r;
    inv_n   = inv_r;
    x_n     = x_r;
    y_n     = y_r;
    sx_n    = sx_r;
    sy_n    = sy_r;
    col_n   = col_r;
    row_n   = row_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          code_n  = code;
          inv_n   = inv_in_s;
          x_n     = {XW{1'b0}};
          y_n     = {YW{1'b0}};
          sx_n    = 3'd0;
          sy_n    = 3'd0;
          col_n   = 3'd0;
          row_n   = 3'd0;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (pix_ready) begin
          if (x_r == X_LAST) begin
            x_n   = {XW{1'b0}};
            sx_n  = 3'd0;
            col_n = 3'd0;
            if (y_r == Y_LAST) begin
              state_n = FIN;
            end else begin
              y_n = y_r + Y_ONE;
              if (sy_r == SY_LAST) begin
                sy_n  = 3'd0;
                row_n = row_r + 3'd1;
              end else begin
                sy_n = sy_r + 3'd1;
              end
            end
          end else begin
            x_n = x_r + X_ONE;
            if (sx_r == SX_LAST) begin
              sx_n  = 3'd0;
              col_n = col_r + 3'd1;
            end else begin
              sx_n = sx_r + 3'd1;
            end
          end
        end else begin
          state_n = RUN;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    row_bits_s = rom_row(code_n, row_n);
    if (state_n == RUN) begin
      on_n = row_bits_s[3'd4 - col_n] ^ inv_n;
    end else begin
      on_n = 1'b0;
    end
  end

  // State, counters and all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      code_r    <= 3'd0;
      inv_r     <= 1'b0;
      x_r       <= {XW{1'b0}};
      y_r       <= {YW{1'b0}};
      sx_r      <= 3'd0;
      sy_r      <= 3'd0;
      col_r     <= 3'd0;
      row_r     <= 3'd0;
      busy      <= 1'b0;
      pix_valid <= 1'b0;
      pix_on    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_n;
      code_r    <= code_n;
      inv_r     <= inv_n;
      x_r       <= x_n;
      y_r       <= y_n;
      sx_r      <= sx_n;
      sy_r      <= sy_n;
      col_r     <= col_n;
      row_r     <= row_n;
      busy      <= (state_n == RUN);
      pix_valid <= (state_n == RUN);
      pix_on    <= on_n;
      done      <= (state_n == FIN);
    end
  end

endmodule

// File: tb/tb_glyph_serializer.sv
// Scoreboard bench for glyph_serializer: two instances (1x1 and 2x3 scaling) checked
// against a bitmap/division reference model, with randomized codes and pix_ready.
module tb_glyph_serializer;

`ifdef GLYPH_INVERT_EN
  localparam bit INV_BUILD = 1'b1;
`else
  localparam bit INV_BUILD = 1'b0;
`endif
  localparam int LIMIT = 2000;

  typedef struct {int x; int y; logic on; bit last;} exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_s [2];
  logic [2:0] code_s  [2];
  logic       inv_s   [2];
  logic       ready_s [2];
  logic       busy_w  [2];
  logic       valid_w [2];
  logic       on_w    [2];
  logic       done_w  [2];
  logic [2:0] xa, ya;
  logic [3:0] xb, yb;

  int checks = 0;
  int failures = 0;
  int rmode [2];
  int done_cnt [2];
  int hs_cnt [2];
  exp_t qa[$];
  exp_t qb[$];

  glyph_serializer #(.SCALE_X(1), .SCALE_Y(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_s[0]), .code(code_s[0]),
`ifdef GLYPH_INVERT_EN
    .invert(inv_s[0]),
`endif
    .busy(busy_w[0]), .pix_valid(valid_w[0]), .pix_ready(ready_s[0]),
    .pix_on(on_w[0]), .pix_x(xa), .pix_y(ya), .done(done_w[0])
  );

  glyph_serializer #(.SCALE_X(2), .SCALE_Y(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_s[1]), .code(code_s[1]),
`ifdef GLYPH_INVERT_EN
    .invert(inv_s[1]),
`endif
    .busy(busy_w[1]), .pix_valid(valid_w[1]), .pix_ready(ready_s[1]),
    .pix_on(on_w[1]), .pix_x(xb), .pix_y(yb), .done(done_w[1])
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int gx(input int sel);
    return (sel == 0) ? int'(xa) : int'(xb);
  endfunction

  function automatic int gy(input int sel);
    return (sel == 0) ? int'(ya) : int'(yb);
  endfunction

  function automatic int scale_x(input int sel);
    return (sel == 0) ? 1 : 2;
  endfunction

  function automatic int scale_y(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  // Reference: glyph bitmap indexed by pixel coordinate divided by the scale factor.
  function automatic logic exp_on(input int sel, input int c, input int inv, input int x, input int y);
    logic [24:0] g;
    int idx;
    logic b;
    case (c)
      1: g = 25'b00100_00100_11111_00100_00100;
      2: g = 25'b00000_00000_11111_00000_00000;
      3: g = 25'b10001_01010_00100_01010_10001;
      4: g = 25'b00100_00000_11111_00000_00100;
      5: g = 25'b00000_11111_00000_11111_00000;
      6: g = 25'b11111_11111_11111_11111_11111;
      default: g = 25'd0;
    endcase
    idx = 24 - ((y / scale_y(sel)) * 5 + x / scale_x(sel));
    b = g[idx];
    return b ^ (INV_BUILD & (inv != 0));
  endfunction

  task automatic push_glyph(input int sel, input int c, input int inv);
    int gw = 5 * scale_x(sel);
    int gh = 5 * scale_y(sel);
    exp_t e;
    for (int y = 0; y < gh; y++) begin
      for (int x = 0; x < gw; x++) begin
        e.x = x;
        e.y = y;
        e.on = exp_on(sel, c, inv, x, y);
        e.last = (x == gw - 1) && (y == gh - 1);
        if (sel == 0) qa.push_back(e);
        else qb.push_back(e);
      end
    end
  endtask

  task automatic monitor(input int sel);
    bit stall = 1'b0;
    bit expect_done = 1'b0;
    int sv_x, sv_y, sv_on, qsize;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
        expect_done = 1'b0;
        continue;
      end
      check("done_timing", int'(done_w[sel]), int'(expect_done));
      if (done_w[sel]) done_cnt[sel]++;
      expect_done = 1'b0;
      if (stall) begin
        check("stall_valid", int'(valid_w[sel]), 1);
        check("stall_x", gx(sel), sv_x);
        check("stall_y", gy(sel), sv_y);
        check("stall_on", int'(on_w[sel]), sv_on);
      end
      stall = 1'b0;
      if (valid_w[sel]) begin
        check("busy_with_valid", int'(busy_w[sel]), 1);
        if (ready_s[sel]) begin
          qsize = (sel == 0) ? qa.size() : qb.size();
          check("pixel_expected", int'(qsize > 0), 1);
          if (qsize > 0) begin
            if (sel == 0) e = qa.pop_front();
            else e = qb.pop_front();
            check("pix_x", gx(sel), e.x);
            check("pix_y", gy(sel), e.y);
            check("pix_on", int'(on_w[sel]), int'(e.on));
            hs_cnt[sel]++;
            expect_done = e.last;
          end
        end else begin
          stall = 1'b1;
          sv_x = gx(sel);
          sv_y = gy(sel);
          sv_on = int'(on_w[sel]);
        end
      end
    end
  endtask

  // pix_ready pattern per instance: 0 high, 1 toggling, 2 random.
  initial begin
    ready_s[0] = 1'b1;
    ready_s[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
        case (rmode[s])
          1:       ready_s[s] = ~ready_s[s];
          2:       ready_s[s] = 1'($urandom_range(0, 1));
          default: ready_s[s] = 1'b1;
        endcase
      end
    end
  end

  task automatic wait_done(input int sel, output int n, output bit drop);
    n = 0;
    drop = 1'b0;
    while (!done_w[sel] && n < LIMIT) begin
      if (!busy_w[sel]) drop = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    check("done_seen", int'(done_w[sel]), 1);
  endtask

  task automatic render(input int sel, input int c, input int inv, input int poke_at, input int exp_edges);
    int n;
    bit drop;
    int d0 = done_cnt[sel];
    int h0 = hs_cnt[sel];
    push_glyph(sel, c, inv);
    start_s[sel] = 1'b1;
    code_s[sel] = 3'(c);
    inv_s[sel] = 1'(inv);
    @(posedge clk);
    #1;
    start_s[sel] = 1'b0;
    code_s[sel] = 3'($urandom_range(0, 7));
    inv_s[sel] = 1'($urandom_range(0, 1));
    check("first_pixel_valid", int'(valid_w[sel]), 1);
    check("busy_after_start", int'(busy_w[sel]), 1);
    n = 0;
    drop = 1'b0;
    while (!done_w[sel] && n < LIMIT) begin
      if (!busy_w[sel]) drop = 1'b1;
      start_s[sel] = (n == poke_at);
      if (n == poke_at) code_s[sel] = 3'd6;
      @(posedge clk);
      #1;
      n++;
    end
    start_s[sel] = 1'b0;
    check("done_seen", int'(done_w[sel]), 1);
    check("busy_held", int'(drop), 0);
    check("busy_low_at_done", int'(busy_w[sel]), 0);
    if (exp_edges >= 0) check("done_latency", n, exp_edges);
    @(posedge clk);
    #1;
    check("done_one_cycle", int'(done_w[sel]), 0);
    check("done_count", done_cnt[sel] - d0, 1);
    check("pixel_count", hs_cnt[sel] - h0, 25 * scale_x(sel) * scale_y(sel));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n, d0, h0;
    bit drop;
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start_s[s] = 1'b0;
      code_s[s] = 3'd0;
      inv_s[s] = 1'b0;
      rmode[s] = 0;
      done_cnt[s] = 0;
      hs_cnt[s] = 0;
    end
    fork
      monitor(0);
      monitor(1);
    join_none
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_busy", int'(busy_w[s]), 0);
      check("rst_valid", int'(valid_w[s]), 0);
      check("rst_done", int'(done_w[s]), 0);
      check("rst_on", int'(on_w[s]), 0);
      check("rst_x", gx(s), 0);
      check("rst_y", gy(s), 0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Multiply glyph at unit scale, ready always high.
    render(0, 3, 0, -1, 25);
    // Toggling ready on the plus glyph.
    rmode[0] = 1;
    render(0, 1, 0, -1, -1);
    rmode[0] = 0;
    // Start pulse with code 6 during RUN is ignored.
    render(0, 3, 0, 5, 25);

    // Start held high: equals, then divide back to back with one idle cycle.
    push_glyph(0, 5, 0);
    push_glyph(0, 4, 0);
    start_s[0] = 1'b1;
    code_s[0] = 3'd5;
    @(posedge clk);
    #1;
    code_s[0] = 3'd4;
    wait_done(0, n, drop);
    check("b2b_latency", n, 25);
    check("b2b_busy_held", int'(drop), 0);
    @(posedge clk);
    #1;
    check("b2b_idle_valid", int'(valid_w[0]), 0);
    check("b2b_idle_busy", int'(busy_w[0]), 0);
    @(posedge clk);
    #1;
    check("b2b_restart_valid", int'(valid_w[0]), 1);
    start_s[0] = 1'b0;
    wait_done(0, n, drop);
    check("b2b_second_latency", n, 25);
    @(posedge clk);
    #1;

    // Reset at pixel 12 of the equals glyph.
    d0 = done_cnt[0];
    h0 = hs_cnt[0];
    push_glyph(0, 5, 0);
    start_s[0] = 1'b1;
    code_s[0] = 3'd5;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    n = 0;
    while (hs_cnt[0] - h0 < 12 && n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_pixel_12", hs_cnt[0] - h0, 12);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", int'(valid_w[0]), 0);
    check("mid_rst_busy", int'(busy_w[0]), 0);
    check("mid_rst_x", gx(0), 0);
    check("mid_rst_y", gy(0), 0);
    qa.delete();
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt[0] - d0, 0);
    render(0, 5, 0, -1, 25);

    // Blank glyph with invert requested (all on only in the invert build).
    render(0, 0, 1, -1, 25);
    render(0, 7, 0, -1, 25);

    // Randomized glyphs and ready on the unit-scale instance.
    rmode[0] = 2;
    for (int k = 0; k < 6; k++) begin
      render(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 30)), -1);
    end

    // Minus glyph at 2x3 scale, then randomized.
    render(1, 2, 0, -1, 150);
    rmode[1] = 2;
    for (int k = 0; k < 2; k++) begin
      render(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 100)), -1);
    end

    check("queue_a_drained", qa.size(), 0);
    check("queue_b_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
